operand_loader: RTL and testbench

//  Operand-entry front end for the GCD engine: the transmitting side of its a/b/start/busy input interface.

---
 rtl/operand_loader_pkg.sv | 16 +
 rtl/button_debounce.sv | 45 ++++
 rtl/operand_loader.sv | 122 ++++++++++++
 tb/tb_operand_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the GCD operand-entry front end.
package operand_loader_pkg;

   typedef enum logic [2:0] {
      StEmpty,
      StGotA,
      StGotB,
      StIssue,
      StRun
   } state_e;

   // RUN gives up after this many cycles if the engine never raised busy.
   localparam int unsigned RunTimeout = 4;
   localparam int unsigned RunCntW    = $clog2(RunTimeout);

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on each debounced 0->1 transition.
module button_debounce #(
   parameter int unsigned DEB_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic press
);

   localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(DEB_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            deb_q;
   logic [CntW-1:0] cnt_q;
   logic            press_q;

   // The counter only runs while the synced level disagrees with the debounced one,
   // so any return to the old level restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b00;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], din};
         press_q <= 1'b0;
         if (sync_q[1] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LastCnt) begin
            deb_q   <= sync_q[1];
            cnt_q   <= '0;
            press_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Operand-entry front end for the GCD engine: latches the switch value into A or B
// on debounced button presses and issues a start pulse once both are held.
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEB_CYCLES = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       bt,
   input  logic [WIDTH-1:0] sw,
   input  logic             busy,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             start,
   output logic             a_vld,
   output logic             b_vld,
   output logic             err
);

   logic               press_a, press_b, any_press;
   logic [WIDTH-1:0]   sw_meta_q, sw_sync_q;
   state_e             state_q;
   logic               busy_q, saw_busy_q;
   logic [RunCntW-1:0] run_cnt_q;

   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk   (clk),
      .rst   (rst),
      .din   (bt[0]),
      .press (press_a)
   );

   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk   (clk),
      .rst   (rst),
      .din   (bt[1]),
      .press (press_b)
   );

   assign any_press = press_a | press_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         a          <= '0;
         b          <= '0;
         a_vld      <= 1'b0;
         b_vld      <= 1'b0;
         start      <= 1'b0;
         err        <= 1'b0;
         busy_q     <= 1'b0;
         saw_busy_q <= 1'b0;
         run_cnt_q  <= '0;
      end else begin
         start  <= 1'b0;
         err    <= 1'b0;
         busy_q <= busy;
         unique case (state_q)
            StEmpty, StGotA, StGotB: begin
               if (any_press) begin
                  if (sw_sync_q == '0) begin
                     err <= 1'b1;
                  end else begin
                     if (press_a) begin
                        a     <= sw_sync_q;
                        a_vld <= 1'b1;
                     end
                     if (press_b) begin
                        b     <= sw_sync_q;
                        b_vld <= 1'b1;
                     end
                     if ((press_a && press_b) || (press_a && state_q == StGotB) ||
                         (press_b && state_q == StGotA)) begin
                        state_q <= StIssue;
                     end else if (press_a) begin
                        state_q <= StGotA;
                     end else begin
                        state_q <= StGotB;
                     end
                  end
               end
            end
            StIssue: begin
               if (any_press) err <= 1'b1;
               if (!busy) begin
                  start      <= 1'b1;
                  state_q    <= StRun;
                  run_cnt_q  <= '0;
                  saw_busy_q <= 1'b0;
               end
            end
            StRun: begin
               if (any_press) err <= 1'b1;
               if (busy) saw_busy_q <= 1'b1;
               // Leave on busy falling, or on timeout if the engine never answered.
               if ((busy_q && !busy) ||
                   (!saw_busy_q && !busy && run_cnt_q == RunCntW'(RunTimeout - 1))) begin
                  state_q <= StEmpty;
                  a_vld   <= 1'b0;
                  b_vld   <= 1'b0;
               end else begin
                  run_cnt_q <= run_cnt_q + 1'b1;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a cycle-level behavioural model.
module tb_operand_loader;

   localparam int unsigned W   = 8;
   localparam int unsigned DEB = 4;
   localparam int unsigned RUN_T = 4;
   localparam int MEmpty = 0, MGotA = 1, MGotB = 2, MIssue = 3, MRun = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   bt = 2'b00;
   logic [W-1:0] sw = '0;
   logic         busy = 1'b0;
   logic [W-1:0] a, b;
   logic         start, a_vld, b_vld, err;

   int n_vec = 0;
   int n_fail = 0;
   int start_cnt = 0;
   int err_cnt = 0;

   // Model state
   int           m_st = MEmpty;
   logic [W-1:0] m_a = '0, m_b = '0;
   bit           m_av, m_bv, m_start, m_err;
   int           m_rc;
   bit           m_saw, m_busy_prev;
   bit           m_deb [2];
   bit           m_pr [2];
   logic [1:0]   bq[$];
   logic [W-1:0] swq[$];

   operand_loader #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
      .clk   (clk),
      .rst   (rst),
      .bt    (bt),
      .sw    (sw),
      .busy  (busy),
      .a     (a),
      .b     (b),
      .start (start),
      .a_vld (a_vld),
      .b_vld (b_vld),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = MEmpty; m_a = '0; m_b = '0; m_av = 0; m_bv = 0;
      m_start = 0; m_err = 0; m_rc = 0; m_saw = 0; m_busy_prev = 0;
      for (int i = 0; i < 2; i++) begin
         m_deb[i] = 0;
         m_pr[i]  = 0;
      end
      bq = {};
      repeat (DEB + 1) bq.push_back(2'b00);
      swq = {};
      repeat (2) swq.push_back('0);
   endtask

   // A button counts as pressed once its raw level has been high for DEB samples,
   // seen two cycles late; the switch value is likewise seen two cycles late.
   task automatic model_step();
      int           st0 = m_st;
      logic [W-1:0] sws = swq[0];
      bit           pa = m_pr[0];
      bit           pb = m_pr[1];
      m_start = 0;
      m_err   = 0;
      if ((pa || pb) && (st0 >= MIssue || sws == '0)) m_err = 1;
      if (st0 < MIssue && (pa || pb) && sws != '0) begin
         if (pa) begin m_a = sws; m_av = 1; end
         if (pb) begin m_b = sws; m_bv = 1; end
         m_st = (m_av && m_bv) ? MIssue : (pa ? MGotA : MGotB);
      end
      if (st0 == MIssue && !busy) begin
         m_start = 1; m_st = MRun; m_rc = 0; m_saw = 0;
      end
      if (st0 == MRun) begin
         if (busy) m_saw = 1;
         m_rc++;
         if ((m_busy_prev && !busy) || (!m_saw && m_rc == RUN_T)) begin
            m_st = MEmpty; m_av = 0; m_bv = 0;
         end
      end
      m_busy_prev = busy;
      for (int k = 0; k < 2; k++) begin
         bit all1 = 1, all0 = 1;
         for (int i = 0; i < DEB; i++) begin
            if (bq[i][k]) all0 = 0; else all1 = 0;
         end
         m_pr[k] = 0;
         if (!m_deb[k] && all1) begin m_deb[k] = 1; m_pr[k] = 1; end
         else if (m_deb[k] && all0) m_deb[k] = 0;
      end
      bq.push_back(bt);  void'(bq.pop_front());
      swq.push_back(sw); void'(swq.pop_front());
   endtask

   always @(posedge clk) begin
      if (rst) model_reset();
      else model_step();
      #1;
      check("a", 32'(a), 32'(m_a));
      check("b", 32'(b), 32'(m_b));
      check("a_vld", 32'(a_vld), 32'(m_av));
      check("b_vld", 32'(b_vld), 32'(m_bv));
      check("start", 32'(start), 32'(m_start));
      check("err", 32'(err), 32'(m_err));
      if (start === 1'b1) start_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [1:0] m, input logic [W-1:0] v);
      sw = v;
      cycles(3);
      bt = m;
      cycles(10);
      bt = 2'b00;
      cycles(DEB + 4);
   endtask

   task automatic wait_start(input string name);
      for (int i = 0; i < 30 && start_cnt == 0; i++) cycles(1);
      check(name, 32'(start_cnt), 32'd1);
   endtask

   initial begin
      cycles(2);
      check("reset_a", 32'(a), 32'd0);
      check("reset_vld", 32'({a_vld, b_vld, start, err}), 32'd0);
      rst = 1'b0;
      cycles(2);

      // 1: bouncing A press
      sw = 8'h24;
      cycles(3);
      bt = 2'b01; cycles(1);
      bt = 2'b00; cycles(1);
      bt = 2'b01; cycles(10);
      bt = 2'b00; cycles(DEB + 4);
      check("t1_a", 32'(a), 32'h24);
      check("t1_vld", 32'({a_vld, b_vld}), 32'b10);
      check("t1_err", 32'(err_cnt), 32'd0);
      check("t1_start", 32'(start_cnt), 32'd0);

      // 2: B completes the pair, engine runs for 5 cycles
      sw = 8'h3C;
      cycles(3);
      bt = 2'b10;
      wait_start("t2_start_seen");
      busy = 1'b1;
      bt = 2'b00;
      cycles(3);
      check("t2_run_vld", 32'({a_vld, b_vld}), 32'b11);
      cycles(2);
      busy = 1'b0;
      cycles(3);
      check("t2_exit_vld", 32'({a_vld, b_vld}), 32'b00);
      check("t2_a", 32'(a), 32'h24);
      check("t2_b", 32'(b), 32'h3C);
      check("t2_start_cnt", 32'(start_cnt), 32'd1);
      cycles(DEB + 4);

      // 3: both loaded while engine busy
      start_cnt = 0;
      busy = 1'b1;
      press(2'b01, 8'h12);
      press(2'b10, 8'h06);
      cycles(20);
      check("t3_held", 32'(start_cnt), 32'd0);
      check("t3_vld", 32'({a_vld, b_vld}), 32'b11);
      busy = 1'b0;
      cycles(1);
      check("t3_first_idle", 32'(start_cnt), 32'd1);
      cycles(8);
      check("t3_timeout_vld", 32'({a_vld, b_vld}), 32'b00);
      check("t3_start_cnt", 32'(start_cnt), 32'd1);

      // 4: zero operand after reset
      rst = 1'b1; cycles(1); rst = 1'b0;
      err_cnt = 0;
      press(2'b01, 8'h00);
      check("t4_err", 32'(err_cnt), 32'd1);
      check("t4_a", 32'(a), 32'd0);
      check("t4_vld", 32'({a_vld, b_vld}), 32'b00);

      // 5: simultaneous A+B
      start_cnt = 0; err_cnt = 0;
      press(2'b11, 8'h11);
      cycles(6);
      check("t5_a", 32'(a), 32'h11);
      check("t5_b", 32'(b), 32'h11);
      check("t5_start", 32'(start_cnt), 32'd1);
      check("t5_err", 32'(err_cnt), 32'd0);

      // 6: press during RUN, then reset aborts
      start_cnt = 0; err_cnt = 0;
      press(2'b01, 8'h05);
      sw = 8'h0A;
      cycles(3);
      bt = 2'b10;
      wait_start("t6_start_seen");
      busy = 1'b1;
      bt = 2'b00;
      cycles(DEB + 4);
      press(2'b01, 8'h77);
      check("t6_err", 32'(err_cnt), 32'd1);
      check("t6_b", 32'(b), 32'h0A);
      check("t6_a", 32'(a), 32'h05);
      check("t6_run_vld", 32'({a_vld, b_vld}), 32'b11);
      rst = 1'b1; cycles(1); rst = 1'b0;
      check("t6_rst_ab", 32'({a, b}), 32'd0);
      check("t6_rst_flags", 32'({a_vld, b_vld, start}), 32'd0);
      busy = 1'b0;
      cycles(10);
      check("t6_no_start", 32'(start_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
